// File: rtl/ifu_fetch_buf.sv
// Instruction fetch unit: owns the fetch PC, issues pipelined ROM reads, pairs words with PCs.
// Latency: response at cycle t is presented to decode at t+1; requests are issued combinationally.
// Backpressure: decode stall holds the head entry; new requests stop when every slot is owned.
module ifu_fetch_buf #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            hold_i,
  output logic            req_valid_o,
  input  logic            req_ready_i,
  output logic [XLEN-1:0] req_addr_o,
  input  logic            rsp_valid_i,
  input  logic [XLEN-1:0] rsp_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [XLEN-1:0] out_inst_o
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW      = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  pc_mem   [DEPTH];
  logic [XLEN-1:0]  inst_mem [DEPTH];
  logic [DEPTH-1:0] filled;

  logic [AW-1:0]    alloc_ptr;
  logic [AW-1:0]    fill_ptr;
  logic [AW-1:0]    head_ptr;
  logic [AW-1:0]    next_head;

  // used: allocated and not yet popped; pend: allocated and not yet filled;
  // drop_cnt: responses still owed for requests killed by a jump.
  logic [CW-1:0]    used;
  logic [CW-1:0]    pend;
  logic [CW-1:0]    drop_cnt;

  logic             accept;
  logic             fill_wr;
  logic             drop_rsp;
  logic             pop;
  logic             fill_next_head;
  logic             next_filled;

  // Request gating, response routing, pop, and the head entry visible after this cycle.
  always_comb begin
    req_valid_o    = rst_n && !hold_i && !jump_en_i &&
                     (({1'b0, used} + {1'b0, drop_cnt}) < DEPTH_W);
    req_addr_o     = fetch_pc;
    accept         = req_valid_o && req_ready_i;
    fill_wr        = rsp_valid_i && !jump_en_i && (drop_cnt == '0);
    drop_rsp       = rsp_valid_i && !jump_en_i && (drop_cnt != '0);
    pop            = out_valid_o && out_ready_i && !jump_en_i;
    next_head      = pop ? head_ptr + AW'(1) : head_ptr;
    fill_next_head = fill_wr && (fill_ptr == next_head);
    next_filled    = filled[next_head] || fill_next_head;
  end

  // Fetch PC, queue pointers, occupancy counters; a jump discards every entry and
  // converts each still-owed response into a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      used      <= '0;
      pend      <= '0;
      drop_cnt  <= '0;
      filled    <= '0;
    end else if (jump_en_i) begin
      fetch_pc  <= jump_addr_i;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      used      <= '0;
      pend      <= '0;
      filled    <= '0;
      // The response arriving this cycle is discarded and settles one owed word.
      drop_cnt  <= drop_cnt + pend - CW'(rsp_valid_i);
    end else begin
      if (accept) begin
        alloc_ptr <= alloc_ptr + AW'(1);
        fetch_pc  <= fetch_pc + XLEN'(4);
      end
      if (fill_wr) begin
        fill_ptr         <= fill_ptr + AW'(1);
        filled[fill_ptr] <= 1'b1;
      end
      if (drop_rsp) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (pop) begin
        head_ptr         <= head_ptr + AW'(1);
        filled[head_ptr] <= 1'b0;
      end
      used <= used + CW'(accept) - CW'(pop);
      pend <= pend + CW'(accept) - CW'(fill_wr);
    end
  end

  // Entry payload storage; validity lives in 'filled', so no reset is needed here.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem[alloc_ptr] <= fetch_pc;
    end
    if (fill_wr) begin
      inst_mem[fill_ptr] <= rsp_data_i;
    end
  end

  // Registered decode interface: mirrors the head entry after this cycle's pop/fill,
  // bypassing a word that lands directly in the new head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      out_pc_o    <= '0;
      out_inst_o  <= '0;
    end else if (jump_en_i) begin
      out_valid_o <= 1'b0;
    end else begin
      out_valid_o <= next_filled;
      if (next_filled) begin
        out_pc_o   <= pc_mem[next_head];
        out_inst_o <= fill_next_head ? rsp_data_i : inst_mem[next_head];
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch_buf.sv
// Bench for ifu_fetch_buf: in-order bus model with random latency plus a queue-level fetch model.
// Expected output stream and request gating come from the model's queues, not the DUT.
// Directed phases cover the listed scenarios, followed by a randomized soak.
module tb_ifu_fetch_buf;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            jump_en_i;
  logic [XLEN-1:0] jump_addr_i;
  logic            hold_i;
  logic            req_valid_o;
  logic            req_ready_i;
  logic [XLEN-1:0] req_addr_o;
  logic            rsp_valid_i;
  logic [XLEN-1:0] rsp_data_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_pc_o;
  logic [XLEN-1:0] out_inst_o;

  always #5 clk = ~clk;

  ifu_fetch_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .hold_i(hold_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_inst_o(out_inst_o)
  );

  typedef struct { logic [31:0] bus_addr; logic [31:0] pc; int due; } bus_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  bus_t        inflight[$];   // accepted reads awaiting a response, in order
  ent_t        exp_q[$];      // words returned and kept, awaiting decode
  int          dead_cnt;      // leading inflight reads issued before the last jump
  logic [31:0] exp_pc;

  int checks, failures, cyc;
  int acc_cnt, pop_cnt, first_acc, first_out;
  logic want_first, got_first, chk_resume, saw_wrap;
  logic [31:0] first_pc, first_inst, last_acc_addr, resume_exp;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  function automatic logic rnd(input int p);
    return ($urandom_range(99, 0) < p);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic reset_checks();
    chk("rst_req_valid", req_valid_o, 1'b0);
    chk("rst_req_addr", req_addr_o, RESET_PC);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_out_pc", out_pc_o, 32'h0);
    chk("rst_out_inst", out_inst_o, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hold_i = 1'b0; jump_en_i = 1'b0; jump_addr_i = '0;
    req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_data_i = '0; out_ready_i = 1'b0;
    inflight.delete(); exp_q.delete();
    dead_cnt = 0; exp_pc = RESET_PC; last_acc_addr = 32'h0;
    first_acc = -1; first_out = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: check outputs against the model, drive inputs, advance model at the edge.
  task automatic step(input int p_rdy, input int p_rsp, input int p_ord, input int p_hold,
                      input int p_jump, input logic [31:0] jaddr);
    bus_t b;
    ent_t e;
    logic acc, popd, rsp, keep;
    logic [31:0] acc_addr;
    chk("out_valid", out_valid_o, exp_q.size() > 0);
    if (out_valid_o && exp_q.size() > 0) begin
      chk("out_pc", out_pc_o, exp_q[0].pc);
      chk("out_inst", out_inst_o, exp_q[0].inst);
    end
    if (out_valid_o && first_out < 0) first_out = cyc;
    if (want_first && out_valid_o) begin
      want_first = 1'b0; got_first = 1'b1; first_pc = out_pc_o; first_inst = out_inst_o;
    end
    hold_i      = rnd(p_hold);
    jump_en_i   = rnd(p_jump);
    jump_addr_i = jaddr;
    req_ready_i = rnd(p_rdy);
    out_ready_i = rnd(p_ord);
    rsp = (inflight.size() > 0) && (inflight[0].due <= cyc) && rnd(p_rsp);
    rsp_valid_i = rsp;
    rsp_data_i  = rsp ? rom(inflight[0].bus_addr) : $urandom;
    #1;
    chk("req_valid", req_valid_o,
        !hold_i && !jump_en_i && (inflight.size() + exp_q.size() < DEPTH));
    acc = req_valid_o && req_ready_i;
    acc_addr = req_addr_o;
    if (acc) begin
      chk("req_addr", acc_addr, exp_pc);
      if (chk_resume) begin
        chk("resume_pc", acc_addr, resume_exp);
        chk_resume = 1'b0;
      end
      if (acc_addr == 32'h0 && last_acc_addr == 32'hFFFF_FFFC) saw_wrap = 1'b1;
      last_acc_addr = acc_addr;
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
    end
    popd = out_valid_o && out_ready_i && !jump_en_i;
    @(posedge clk);
    keep = 1'b0;
    b.bus_addr = '0; b.pc = '0; b.due = 0;
    if (rsp) begin
      b = inflight.pop_front();
      if (dead_cnt > 0) dead_cnt--;
      else keep = !jump_en_i;
    end
    if (popd && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      pop_cnt++;
    end
    if (keep) begin
      e.pc = b.pc; e.inst = rom(b.pc);
      exp_q.push_back(e);
    end
    if (jump_en_i) begin
      exp_q.delete();
      dead_cnt = inflight.size();
      exp_pc = jump_addr_i;
    end
    if (acc) begin
      b.bus_addr = acc_addr; b.pc = exp_pc; b.due = cyc + 1;
      inflight.push_back(b);
      exp_pc = exp_pc + 32'd4;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, p0;
    checks = 0; failures = 0; cyc = 0; acc_cnt = 0; pop_cnt = 0;
    want_first = 1'b0; got_first = 1'b0; chk_resume = 1'b0; saw_wrap = 1'b0;
    first_pc = '0; first_inst = '0; resume_exp = '0;
    rst_n = 1'b0; hold_i = 1'b0; jump_en_i = 1'b0; jump_addr_i = '0;
    req_ready_i = 1'b1; rsp_valid_i = 1'b0; rsp_data_i = '0; out_ready_i = 1'b1;
    #3;
    reset_checks();
    do_reset();

    // Streaming with a one-cycle ROM.
    repeat (20) step(100, 100, 100, 0, 0, 32'h0);
    chk("first_out_latency", first_out - first_acc, 2);

    // Decode stalled: exactly DEPTH requests, then four back-to-back pops.
    do_reset();
    acc_cnt = 0;
    repeat (12) step(100, 100, 0, 0, 0, 32'h0);
    chk("stall_accepts", acc_cnt, DEPTH);
    pop_cnt = 0;
    repeat (4) step(100, 100, 100, 0, 0, 32'h0);
    chk("drain_pops", pop_cnt, 4);
    repeat (6) step(100, 100, 100, 0, 0, 32'h0);

    // Jump with several reads in flight.
    for (int i = 0; i < 10 && inflight.size() < 3; i++) step(100, 0, 100, 0, 0, 32'h0);
    chk("inflight_before_jump", inflight.size() >= 3, 1'b1);
    step(100, 0, 100, 0, 100, 32'h100);
    want_first = 1'b1; got_first = 1'b0;
    repeat (15) step(100, 100, 100, 0, 0, 32'h0);
    chk("jump1_seen", got_first, 1'b1);
    chk("jump1_pc", first_pc, 32'h100);
    chk("jump1_inst", first_inst, rom(32'h100));

    // Jump coinciding with a response.
    repeat (2) step(100, 100, 100, 0, 0, 32'h0);
    step(100, 100, 100, 0, 100, 32'h200);
    want_first = 1'b1; got_first = 1'b0;
    repeat (15) step(100, 100, 100, 0, 0, 32'h0);
    chk("jump2_seen", got_first, 1'b1);
    chk("jump2_pc", first_pc, 32'h200);
    chk("jump2_inst", first_inst, rom(32'h200));

    // Hold for five cycles while words are still in flight.
    repeat (2) step(100, 0, 100, 0, 0, 32'h0);
    resume_exp = last_acc_addr + 32'd4;
    a0 = acc_cnt; p0 = pop_cnt;
    repeat (5) step(100, 100, 100, 100, 0, 32'h0);
    chk("hold_no_req", acc_cnt - a0, 0);
    chk("hold_drain", pop_cnt > p0, 1'b1);
    chk_resume = 1'b1;
    repeat (5) step(100, 100, 100, 0, 0, 32'h0);
    chk("resume_seen", chk_resume, 1'b0);

    // PC wrap at the top of the address space.
    saw_wrap = 1'b0;
    step(100, 100, 100, 0, 100, 32'hFFFF_FFF4);
    repeat (10) step(100, 100, 100, 0, 0, 32'h0);
    chk("pc_wrap", saw_wrap, 1'b1);

    // Asynchronous reset in the middle of a burst.
    repeat (3) step(100, 100, 100, 0, 0, 32'h0);
    chk("pre_reset_valid", out_valid_o, 1'b1);
    #2 rst_n = 1'b0;
    #1 reset_checks();
    do_reset();

    // Randomized soak.
    repeat (3000) step(70, 60, 70, 10, 3, $urandom & 32'hFFFF_FFFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
